// File: rtl/ah_credit_rx_buffer.sv
// rtl/ah_credit_rx_buffer.sv - receive-side credit buffer in front of the w2n packet converter
//
// Purpose:
//   Holds WIDTH-bit words from a credit-flow-controlled link in a DEPTH-entry
//   FIFO. The words are presented downstream over valid/ready. One credit is
//   returned for every entry freed. DEPTH initial credits are issued after reset.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   wdata      link write data
//   wvalid     link write strobe (sender only asserts it while it holds a credit)
//   wcredit    one-cycle credit-return pulse, one pulse per entry
//   rdata      FIFO head data (0 while empty)
//   rvalid     FIFO non-empty
//   rready     converter accepts the head word
//   ovf_err    (AH_CREDIT_RX_STATUS_EN only) sticky overflow flag
//   init_done  (AH_CREDIT_RX_STATUS_EN only) initial credit burst completed
//
// Optional feature macro: AH_CREDIT_RX_STATUS_EN
module ah_credit_rx_buffer #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvalid,
  output logic             wcredit,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             rready
`ifdef AH_CREDIT_RX_STATUS_EN
  ,
  output logic             ovf_err,
  output logic             init_done
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CW-1:0]    pending_q, pending_d;
  logic             wcredit_q, credit_d;
  logic             full, push, pop;

  // A pop in the same cycle never frees room for a push into a full FIFO.
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign push    = wvalid && !full;
  assign rvalid  = (count_q != '0);
  assign pop     = rvalid && rready;
  assign rdata   = rvalid ? mem_q[rd_ptr_q] : '0;
  assign wcredit = wcredit_q;

  always_comb begin
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    // At most one credit per cycle; pending absorbs pops that arrive while
    // the initial burst is still draining, so no credit is ever lost.
    credit_d  = (pending_q != '0) | pop;
    pending_d = pending_q + CW'(pop) - CW'(credit_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= CW'(DEPTH);
      wcredit_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      wcredit_q <= credit_d;
    end
  end

  // Storage needs no reset: rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

`ifdef AH_CREDIT_RX_STATUS_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e state_q, state_d;
  logic   ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (pending_d == '0) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_q | (wvalid && full);
    end
  end

  assign ovf_err   = ovf_q;
  assign init_done = (state_q == ST_RUN);
`endif

endmodule

// File: tb/tb_ah_credit_rx_buffer.sv
// tb/tb_ah_credit_rx_buffer.sv - directed self-checking bench for ah_credit_rx_buffer
module tb_ah_credit_rx_buffer;

  localparam int WIDTH = 20;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] wdata;
  logic             wvalid;
  logic             wcredit;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rready;
`ifdef AH_CREDIT_RX_STATUS_EN
  logic             ovf_err;
  logic             init_done;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ah_credit_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wdata   (wdata),
    .wvalid  (wvalid),
    .wcredit (wcredit),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready)
`ifdef AH_CREDIT_RX_STATUS_EN
    ,
    .ovf_err  (ovf_err),
    .init_done(init_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rvalid !== 1'b0 || wcredit !== 1'b0 || rdata !== '0) begin
      n_err++;
      $display("FAIL reset_state: rvalid=%b wcredit=%b rdata=%h, want 0 0 0", rvalid, wcredit, rdata);
    end
    rstn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++;
      if (wcredit !== (i <= DEPTH)) begin
        n_err++;
        $display("FAIL init_credit cycle %0d: wcredit=%b want %b", i, wcredit, (i <= DEPTH));
      end
      n_cmp++;
      if (rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL init_rvalid cycle %0d: rvalid=%b want 0", i, rvalid);
      end
`ifdef AH_CREDIT_RX_STATUS_EN
      n_cmp++;
      if (init_done !== (i >= DEPTH)) begin
        n_err++;
        $display("FAIL init_done cycle %0d: %b want %b", i, init_done, (i >= DEPTH));
      end
`endif
    end
  endtask

  task automatic test_push_pop();
    logic [WIDTH-1:0] exp_rd [2];
    logic             exp_cr [2];
    logic             exp_rv [2];
    exp_rd = '{20'hABCDE, 20'h00000};
    exp_rv = '{1'b1, 1'b0};
    exp_cr = '{1'b1, 1'b1};
    wvalid = 1'b1; wdata = 20'h12345; rready = 1'b0;
    tick();
    wdata = 20'hABCDE;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 20'h12345 || wcredit !== 1'b0) begin
      n_err++;
      $display("FAIL push_first: rvalid=%b rdata=%h wcredit=%b want 1 12345 0", rvalid, rdata, wcredit);
    end
    tick();
    wvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 20'h12345 || wcredit !== 1'b0) begin
      n_err++;
      $display("FAIL push_second: rvalid=%b rdata=%h wcredit=%b want 1 12345 0", rvalid, rdata, wcredit);
    end
    rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (rvalid !== exp_rv[i] || rdata !== exp_rd[i] || wcredit !== exp_cr[i]) begin
        n_err++;
        $display("FAIL pop_%0d: rvalid=%b rdata=%h wcredit=%b want %b %h %b",
                 i, rvalid, rdata, wcredit, exp_rv[i], exp_rd[i], exp_cr[i]);
      end
    end
    rready = 1'b0;
    tick();
    n_cmp++;
    if (wcredit !== 1'b0) begin
      n_err++;
      $display("FAIL pop_idle_credit: wcredit=%b want 0", wcredit);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] words [4];
    int               credits;
    words = '{20'h11111, 20'h22222, 20'h33333, 20'h44444};
    credits = 0;
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1;
      wdata  = (i < 4) ? words[i] : 20'h00001;
      tick();
      credits += int'(wcredit);
    end
    wvalid = 1'b0;
`ifdef AH_CREDIT_RX_STATUS_EN
    n_cmp++;
    if (ovf_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_err_set: %b want 1", ovf_err);
    end
`endif
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== words[i]) begin
        n_err++;
        $display("FAIL ovf_order %0d: rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, words[i]);
      end
      tick();
      credits += int'(wcredit);
    end
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_dropped: rvalid=%b rdata=%h want empty", rvalid, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      credits += int'(wcredit);
    end
    n_cmp++;
    if (credits != 4) begin
      n_err++;
      $display("FAIL ovf_credits: got %0d want 4", credits);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] d;
    int               credits, pushes, pops, creds;
    logic             do_pop;
    credits = DEPTH; pushes = 0; pops = 0; creds = 0;
    rready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      d      = WIDTH'($urandom);
      wdata  = d;
      wvalid = (c < 20) && (credits > 0);
      do_pop = rvalid;
      n_cmp++;
      if (rvalid !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL stream_rvalid c%0d: %b want %b", c, rvalid, (q.size() != 0));
      end
      if (rvalid === 1'b1 && q.size() != 0) begin
        n_cmp++;
        if (rdata !== q[0]) begin
          n_err++;
          $display("FAIL stream_data c%0d: rdata=%h want %h", c, rdata, q[0]);
        end
      end
      tick();
      if (do_pop && q.size() != 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (wvalid) begin
        q.push_back(d);
        credits--;
        pushes++;
      end
      n_cmp++;
      if (wcredit !== do_pop) begin
        n_err++;
        $display("FAIL stream_credit c%0d: wcredit=%b want %b", c, wcredit, do_pop);
      end
      credits += int'(wcredit);
      creds   += int'(wcredit);
    end
    wvalid = 1'b0;
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0 || pops != pushes || creds != pops || pushes < 15) begin
      n_err++;
      $display("FAIL stream_totals: rvalid=%b pushes=%0d pops=%0d credits=%0d want empty, equal, >=15",
               rvalid, pushes, pops, creds);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] words [3];
    words = '{20'h0AAAA, 20'h0BBBB, 20'h0CCCC};
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1;
      wdata  = words[i];
      tick();
    end
    wvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 20'h0AAAA) begin
      n_err++;
      $display("FAIL mid_pre: rvalid=%b rdata=%h want 1 0aaaa", rvalid, rdata);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (rvalid !== 1'b0 || wcredit !== 1'b0 || rdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async: rvalid=%b wcredit=%b rdata=%h want 0 0 0", rvalid, wcredit, rdata);
    end
`ifdef AH_CREDIT_RX_STATUS_EN
    n_cmp++;
    if (ovf_err !== 1'b0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_status: ovf_err=%b init_done=%b want 0 0", ovf_err, init_done);
    end
`endif
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++;
      if (wcredit !== (i <= DEPTH) || rvalid !== 1'b0 || rdata !== '0) begin
        n_err++;
        $display("FAIL mid_burst cycle %0d: wcredit=%b rvalid=%b rdata=%h want %b 0 0",
                 i, wcredit, rvalid, rdata, (i <= DEPTH));
      end
    end
    wvalid = 1'b1;
    wdata  = 20'h05555;
    tick();
    wvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 20'h05555) begin
      n_err++;
      $display("FAIL mid_new_data: rvalid=%b rdata=%h want 1 05555", rvalid, rdata);
    end
  endtask

  initial begin
    rstn   = 1'b0;
    wdata  = '0;
    wvalid = 1'b0;
    rready = 1'b0;
    tick();
    tick();
    test_reset();
    test_push_pop();
    test_overflow();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
